// File: rtl/fifo_word_serializer.sv
// Pops DATA_W-bit words from a show-ahead FIFO and streams each one out MSB-first
// as DATA_W/OUT_W narrow beats on a valid/ready interface.
module fifo_word_serializer #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              empty,
  input  logic [DATA_W-1:0] pop_data,
  output logic              pop,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              out_last,
  input  logic              drop,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEATS = DATA_W / OUT_W;
  localparam int BC_W  = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg_p0;
  logic [BC_W-1:0]   beat_cnt_p0;
  logic              vld_p0;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              hs, last_beat, do_shift, do_clear;

  assign hs        = vld_p0 & out_ready;
  assign last_beat = (beat_cnt_p0 == LAST_BEAT);

  // Drop wins over a handshake: the beat on the bus is discarded, not transferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    do_shift  = 1'b0;
    do_clear  = 1'b0;
    case (state)
      IDLE: begin
        pop = rstn & ~empty & ~drop;
        if (pop) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (drop) begin
          state_nxt = IDLE;
          do_clear  = 1'b1;
        end else if (hs) begin
          if (last_beat) begin
            pop = rstn & ~empty;
            if (!pop) begin
              state_nxt = IDLE;
              do_clear  = 1'b1;
            end
          end else begin
            do_shift = 1'b1;
          end
        end
      end
    endcase
  end

  // Stage p0: shift register, beat counter and beat valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      shreg_p0    <= '0;
      beat_cnt_p0 <= '0;
      vld_p0      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        shreg_p0    <= pop_data;
        beat_cnt_p0 <= '0;
        vld_p0      <= 1'b1;
        word_cnt_q  <= word_cnt_q + CNT_W'(1);
      end else if (do_clear) begin
        beat_cnt_p0 <= '0;
        vld_p0      <= 1'b0;
      end else if (do_shift) begin
        shreg_p0    <= shreg_p0 << OUT_W;
        beat_cnt_p0 <= beat_cnt_p0 + BC_W'(1);
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = shreg_p0[DATA_W-1 -: OUT_W];
  assign out_last  = last_beat;
  assign busy      = (state == SHIFT);
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: a small FIFO model feeds the DUT and a
// scoreboard queue of expected beats is drained by an independent monitor.
module tb_fifo_word_serializer;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 4;
  localparam int BEATS  = DATA_W / OUT_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              empty;
  logic [DATA_W-1:0] pop_data;
  logic              pop;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;
  logic              out_last;
  logic              drop;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] mem [0:63];
  logic [5:0]  wr_ptr = 6'd0;
  logic [5:0]  rd_ptr = 6'd0;
  int          checks = 0;
  int          errors = 0;
  int          pop_count = 0;
  int          base;

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .empty(empty), .pop_data(pop_data), .pop(pop),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .drop(drop), .busy(busy), .word_cnt(word_cnt)
  );

  // Show-ahead FIFO model
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr];
  always @(posedge clk) if (pop) rd_ptr <= rd_ptr + 6'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    beat_t e;
    mem[wr_ptr] = w;
    for (int b = 0; b < BEATS; b++) begin
      e.data = w[31-8*b -: 8];
      e.last = (b == BEATS - 1);
      exp_q.push_back(e);
    end
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  // Monitor: mid-cycle, predicts what the next rising edge transfers
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (pop) pop_count++;
        if (empty) check("no_pop_when_empty", {31'b0, pop}, 32'd0);
        if (pop && busy) check("pop_on_last_hs", {31'b0, out_valid & out_ready & out_last}, 32'd1);
        if (drop && busy) begin
          while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.last) break;
          end
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", out_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("beat_data", {24'b0, out_data}, {24'b0, mon_e.data});
            check("beat_last", {31'b0, out_last}, {31'b0, mon_e.last});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; out_ready = 1'b0; drop = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pop", {31'b0, pop}, 32'd0);
    check("rst_word_cnt", {28'b0, word_cnt}, 32'd0);
    rstn = 1'b1; out_ready = 1'b1;
    tick();

    // Single word, one-cycle latency
    base = pop_count;
    push_word(32'hFFFFFFFF);
    #1 check("t1_pop_comb", {31'b0, pop}, 32'd1);
    tick();
    check("t1_latency_valid", {31'b0, out_valid}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    drain();
    check("t1_pop_count", pop_count - base, 32'd1);
    check("t1_word_cnt", {28'b0, word_cnt}, 32'd1);
    check("t1_idle", {31'b0, busy}, 32'd0);

    // Back-to-back words with no bubble
    base = pop_count;
    push_word(32'hFFFFFF9B);
    push_word(32'hFFFFFF37);
    wait_valid();
    for (int i = 0; i < 8; i++) begin
      check("t2_no_gap", {31'b0, out_valid}, 32'd1);
      tick();
    end
    check("t2_idle_after", {31'b0, out_valid}, 32'd0);
    check("t2_pop_count", pop_count - base, 32'd2);
    check("t2_word_cnt", {28'b0, word_cnt}, 32'd3);
    drain();

    // Backpressure after the first beat
    base = pop_count;
    push_word(32'h12345678);
    wait_valid();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_valid", {31'b0, out_valid}, 32'd1);
      check("t3_stall_data", {24'b0, out_data}, 32'h34);
      tick();
    end
    check("t3_stall_hold", {24'b0, out_data}, 32'h34);
    out_ready = 1'b1;
    drain();
    check("t3_pop_count", pop_count - base, 32'd1);
    check("t3_word_cnt", {28'b0, word_cnt}, 32'd4);

    // Drop mid-word with a second word queued
    base = pop_count;
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    wait_valid();
    tick();
    tick();
    drop = 1'b1;
    #1 check("t4_drop_no_pop", {31'b0, pop}, 32'd0);
    check("t4_drop_data", {24'b0, out_data}, 32'hCC);
    tick();
    drop = 1'b0;
    check("t4_gap_valid", {31'b0, out_valid}, 32'd0);
    check("t4_gap_busy", {31'b0, busy}, 32'd0);
    #1 check("t4_repop", {31'b0, pop}, 32'd1);
    tick();
    check("t4_next_valid", {31'b0, out_valid}, 32'd1);
    check("t4_next_data", {24'b0, out_data}, 32'h01);
    drain();
    check("t4_pop_count", pop_count - base, 32'd2);
    check("t4_word_cnt", {28'b0, word_cnt}, 32'd6);

    // Empty FIFO, then asynchronous reset mid-word
    for (int i = 0; i < 20; i++) begin
      check("t5_empty_valid", {31'b0, out_valid}, 32'd0);
      check("t5_empty_pop", {31'b0, pop}, 32'd0);
      tick();
    end
    push_word(32'h11223344);
    wait_valid();
    tick();
    rstn = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_word_cnt", {28'b0, word_cnt}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_data", {24'b0, out_data}, 32'd0);
    exp_q.delete();
    tick();
    rstn = 1'b1;
    tick();
    check("t5_no_repop", {31'b0, out_valid}, 32'd0);

    // Counter wrap: 17 words through a 4-bit counter
    base = pop_count;
    for (int i = 0; i < 17; i++) begin
      logic [7:0] bv;
      bv = 8'(i + 1);
      push_word({bv, ~bv, bv, 8'h5A});
    end
    drain();
    check("t6_pop_count", pop_count - base, 32'd17);
    check("t6_word_cnt_wrap", {28'b0, word_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Downstream consumer of the shift-register FIFO.
- Pops DATA_W-bit words through the FIFO's push/pop/empty interface and emits each word as DATA_W/OUT_W narrow beats, MSB-first, on a valid/ready stream.
- Sits between the FIFO's pop side and a narrow byte-wide sink, such as a serial link packer.

Parameters:
- DATA_W, 32: FIFO word width. Must be an integer multiple of OUT_W.
- OUT_W, 8: output beat width.
- BEATS, DATA_W/OUT_W: beats per word (derived localparam). Must be ≥2.
- CNT_W, 16: width of the consumed-word counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- empty  in  1  FIFO empty flag.
- pop_data  in  DATA_W  FIFO head word. Show-ahead: valid whenever empty=0; removed at the edge where pop=1.
- pop  out  1  FIFO pop request (combinational).
- out_valid  out  1  output beat valid (registered).
- out_data  out  OUT_W  output beat (registered).
- out_ready  in  1  sink ready.
- out_last  out  1  high on the final beat of a word.
- drop  in  1  synchronous abort of the word currently being serialized.
- busy  out  1  high while in SHIFT.
- word_cnt  out  CNT_W  number of words popped, modulo 2^CNT_W.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; out_valid=0; out_data=0; out_last=0.
  - Shift register=0; beat_cnt=0; word_cnt=0; busy=0; pop=0.
- States: IDLE, SHIFT.
- Handshake: a beat transfers on any edge where out_valid=1 and out_ready=1 ("hs").
- pop = rstn & ~empty & ~drop & (state==IDLE | (state==SHIFT & hs & beat_cnt==BEATS-1)).
  - Never pop when empty=1.
  - Pop at most once per cycle.
- Load (on any edge with pop=1):
  - shreg<=pop_data; beat_cnt<=0; out_valid<=1; word_cnt<=word_cnt+1 (wraps).
  - State becomes or stays SHIFT.
- Outputs:
  - out_data = shreg[DATA_W-1 -: OUT_W].
  - out_last = (beat_cnt==BEATS-1).
  - busy = (state==SHIFT).
- SHIFT, hs with beat_cnt<BEATS-1: shreg<=shreg<<OUT_W; beat_cnt++.
- SHIFT, hs on the last beat:
  - If pop: reload. Back-to-back words, no bubble.
  - Else: out_valid<=0; state<=IDLE.
- SHIFT, no hs: out_valid, out_data and out_last are held stable. A beat is never withdrawn or changed while stalled.
- Latency: empty falling in IDLE → pop that same cycle → out_valid=1 after the next edge (1 cycle).
- Throughput: with out_ready held at 1 and the FIFO non-empty, exactly BEATS beats per word, continuous.
- drop=1 in SHIFT:
  - Overrides hs. The current beat is not counted as transferred and pop=0.
  - Next edge: out_valid=0; state=IDLE; beat_cnt=0. The remaining beats are discarded.
- drop=1 in IDLE: ignored for state, but suppresses pop that cycle.
- Reset mid-word: the partial word is lost. No re-pop; word_cnt restarts at 0.
- empty rising mid-word: has no effect until the last beat.

Test Plan:
- Reset then single word: push 0xFFFFFFFF, out_ready=1.
  - Required: pop for 1 cycle; out_data FF,FF,FF,FF on 4 consecutive cycles; out_last only on the 4th; word_cnt=1; back to IDLE.
- Back-to-back: push 0xFFFFFF9B then 0xFFFFFF37, out_ready=1.
  - Required: 8 contiguous beats FF,FF,FF,9B,FF,FF,FF,37; second pop coincides with the first word's last hs; no out_valid gap.
- Backpressure: out_ready=0 for 3 cycles after beat 1 of 0x12345678.
  - Required: out_data held at 0x34 with out_valid=1 throughout; stream resumes 34,56,78; exactly one pop.
- Drop: assert drop for 1 cycle during beat 2 of 0xAABBCCDD with a second word 0x01020304 queued.
  - Required: out_valid low for 1 cycle; next beats 01,02,03,04; word_cnt=2.
- Empty FIFO: hold empty=1 for 20 cycles.
  - Required: pop never asserts; out_valid stays 0.
  - Then pulse rstn low mid-word: out_valid=0 immediately (async); word_cnt=0.
- Counter wrap: with CNT_W=4, stream 17 words.
  - Required: word_cnt reads 1 after the 17th pop.
